// File: rtl/mmio_uart.sv
// mmio_uart: word-addressed 8N1 UART with TX FIFO and one RX holding register.
// Reads are combinational from addr; writes and read side effects act at posedge.
module mmio_uart #(
    parameter int unsigned TX_DEPTH  = 8,
    parameter logic [15:0] DIV_RESET = 16'd867
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] addr,
    input  logic        re,
    output logic [31:0] rd,
    input  logic        we,
    input  logic [31:0] wd,
    input  logic        rx,
    output logic        tx
);
    localparam int unsigned PW = $clog2(TX_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(TX_DEPTH);

    typedef enum logic [1:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
    } rx_state_e;

    // register decode
    logic sel_data, sel_stat, sel_div;
    logic push, push_ok, pop;
    logic rd_clr, st_clr;
    logic full, empty, tx_empty;
    logic [5:0] status;

    // baud divisor
    logic [15:0] div_q, div_d;

    // TX FIFO
    logic [7:0]    mem_q [TX_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // TX engine
    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        tx_q, tx_d;

    // RX engine
    logic        rx_s1_q, rx_s2_q;
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_load, ferr_set;
    logic [16:0] half;
    logic [15:0] half_ld;

    // sticky flags
    logic ovr_q, ovr_d;
    logic drop_q, drop_d;
    logic ferr_q, ferr_d;

    logic unused_bits;

    assign unused_bits = ^{addr[29:2], wd[31:16]};

    assign sel_data = (addr[1:0] == 2'd0);
    assign sel_stat = (addr[1:0] == 2'd1);
    assign sel_div  = (addr[1:0] == 2'd2);

    assign full     = (cnt_q == DEPTH_C);
    assign empty    = (cnt_q == '0);
    assign push     = we & sel_data;
    assign push_ok  = push & ~full;
    assign rd_clr   = re & sel_data;
    assign st_clr   = re & sel_stat;
    assign tx_empty = empty & (tx_state_q == TX_IDLE);
    assign tx       = tx_q;

    assign status = {ferr_q, drop_q, ovr_q, rx_valid_q, tx_empty, full};

    // half-bit wait for start-bit validation, at least one clock
    assign half    = ({1'b0, div_q} + 17'd1) >> 1;
    assign half_ld = (half == 17'd0) ? 16'd0 : 16'(half - 17'd1);

    // combinational read mux, independent of re
    always_comb begin
        rd = 32'd0;
        unique case (addr[1:0])
            2'd0:    rd = {24'd0, rx_data_q};
            2'd1:    rd = {26'd0, status};
            2'd2:    rd = {16'd0, div_q};
            default: rd = 32'd0;
        endcase
    end

    // FIFO pointers, count, divisor and sticky flag next state
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + PW'(1);
        if (pop)     rptr_d = rptr_q + PW'(1);
        cnt_d  = cnt_q + CW'(push_ok) - CW'(pop);
        div_d  = (we & sel_div) ? wd[15:0] : div_q;
        rx_data_d  = rx_load ? rx_sh_q : rx_data_q;
        rx_valid_d = rx_load | (rx_valid_q & ~rd_clr);
        ovr_d  = (rx_load & rx_valid_q & ~rd_clr) | (ovr_q & ~st_clr);
        drop_d = (push & full) | (drop_q & ~st_clr);
        ferr_d = ferr_set | (ferr_q & ~st_clr);
    end

    // TX framing: start, 8 data bits LSB first, stop, chained when FIFO has more
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    tx_state_d = TX_START;
                    tx_cnt_d   = div_q;
                    tx_sh_d    = mem_q[rptr_q];
                    tx_d       = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q != 16'd0) begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end else begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = div_q;
                    tx_bit_d   = 3'd0;
                    tx_d       = tx_sh_q[0];
                    tx_sh_d    = {1'b0, tx_sh_q[7:1]};
                end
            end
            TX_DATA: begin
                if (tx_cnt_q != 16'd0) begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end else if (tx_bit_q == 3'd7) begin
                    tx_state_d = TX_STOP;
                    tx_cnt_d   = div_q;
                    tx_d       = 1'b1;
                end else begin
                    tx_bit_d = tx_bit_q + 3'd1;
                    tx_cnt_d = div_q;
                    tx_d     = tx_sh_q[0];
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                end
            end
            TX_STOP: begin
                if (tx_cnt_q != 16'd0) begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end else if (!empty) begin
                    pop        = 1'b1;
                    tx_state_d = TX_START;
                    tx_cnt_d   = div_q;
                    tx_sh_d    = mem_q[rptr_q];
                    tx_d       = 1'b0;
                end else begin
                    tx_state_d = TX_IDLE;
                    tx_d       = 1'b1;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    // RX framing: validate start at mid-bit, then sample each bit a full period apart
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_load    = 1'b0;
        ferr_set   = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = half_ld;
                end
            end
            RX_START: begin
                if (rx_cnt_q != 16'd0) begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end else if (!rx_s2_q) begin
                    rx_state_d = RX_DATA;
                    rx_cnt_d   = div_q;
                    rx_bit_d   = 3'd0;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q != 16'd0) begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end else begin
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_cnt_d = div_q;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q != 16'd0) begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end else if (rx_s2_q) begin
                    rx_load    = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    ferr_set   = 1'b1;
                    rx_state_d = RX_WAIT;
                end
            end
            RX_WAIT: begin
                if (rx_s2_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // FIFO storage needs no reset; emptiness is tracked by the count
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wd[7:0];
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= DIV_RESET;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_sh_q    <= 8'd0;
            tx_q       <= 1'b1;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'd0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            drop_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            div_q      <= div_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_q       <= tx_d;
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
            drop_q     <= drop_d;
            ferr_q     <= ferr_d;
        end
    end

endmodule
